// File: rtl/mavg_channel_scheduler.sv
// Multi-channel moving-average engine. One shared window RAM and one
// accumulator-update datapath serve NUM_CH independent sample streams.
// A round-robin arbiter picks one pending channel at a time. A 4-state FSM
// then walks it through RAM read, accumulate/write and output.
//
// Handshakes (both sides strict valid/ready):
//   x side: a sample on channel c transfers on a rising edge where
//           x_valid[c] && x_ready[c]. x_ready is one-hot, combinational, and
//           only ever high in IDLE. x_valid may drop freely while ungranted.
//   y side: y_valid/y_data/y_ch are held stable until the edge where
//           y_valid && y_ready, which completes the transfer.
module mavg_channel_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int WIND_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] x_data,
    input  logic [NUM_CH-1:0]            x_valid,
    output logic [NUM_CH-1:0]            x_ready,
    input  logic [NUM_CH-1:0]            ch_clear,
    output logic [DATA_WIDTH-1:0]        y_data,
    output logic [$clog2(NUM_CH)-1:0]    y_ch,
    output logic                         y_valid,
    input  logic                         y_ready,
    output logic                         busy
);

    localparam int CH_W       = $clog2(NUM_CH);
    localparam int WIND_DEPTH = 2 ** WIND_WIDTH;
    localparam int ACC_W      = DATA_WIDTH + WIND_WIDTH;
    localparam int ADDR_W     = CH_W + WIND_WIDTH;
    localparam int RAM_WORDS  = NUM_CH * WIND_DEPTH;
    localparam logic [WIND_WIDTH-1:0] PTR_MAX = WIND_WIDTH'(WIND_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_UPDATE = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Per-channel state
    logic [ACC_W-1:0]      acc [NUM_CH];
    logic [WIND_WIDTH-1:0] ptr [NUM_CH];
    logic [NUM_CH-1:0]     full;
    logic [NUM_CH-1:0]     pending_clr;

    // In-flight transaction
    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       ch_q;
    logic [DATA_WIDTH-1:0] x_q;
    logic                  out_ok;

    // Shared window RAM
    logic [DATA_WIDTH-1:0] ram [RAM_WORDS];
    logic [DATA_WIDTH-1:0] ram_dout;
    logic [ADDR_W-1:0]     ram_addr;
    logic                  ram_we;

    // Arbitration / clear selection
    logic                  clr_any;
    logic [CH_W-1:0]       clr_idx;
    logic [NUM_CH-1:0]     clr_mask;
    logic                  win_found;
    logic [CH_W-1:0]       win_idx;
    logic                  grant_fire;
    logic [ACC_W-1:0]      old_val;

    // Lowest-index pending clear; iterate downward so the lowest set bit wins.
    always_comb begin
        clr_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_clr[i]) begin
                clr_idx = CH_W'(i);
            end
        end
        clr_any = |pending_clr;
    end

    // Round-robin winner starting at rr_ptr; downward scan keeps the closest offset.
    always_comb begin
        logic [CH_W-1:0] idx;
        win_idx   = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = rr_ptr + CH_W'(i);
            if (x_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Grant, clear mask and datapath helpers; clears always pre-empt samples.
    always_comb begin
        grant_fire = (state == S_IDLE) && !clr_any && win_found;
        clr_mask   = '0;
        if ((state == S_IDLE) && clr_any) begin
            clr_mask[clr_idx] = 1'b1;
        end
        x_ready = '0;
        if (grant_fire && reset_n) begin
            x_ready[win_idx] = 1'b1;
        end
        ram_addr = {ch_q, ptr[ch_q]};
        ram_we   = (state == S_UPDATE);
        old_val  = full[ch_q] ? ACC_W'(ram_dout) : '0;
    end

    // Output presentation; everything reads zero unless a result is offered.
    always_comb begin
        busy    = (state != S_IDLE);
        y_valid = (state == S_OUT) && out_ok;
        y_data  = y_valid ? acc[ch_q][ACC_W-1:WIND_WIDTH] : '0;
        y_ch    = y_valid ? ch_q : '0;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: grant -> read -> update -> out -> idle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (grant_fire) state_nxt = S_READ;
            S_READ:   state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = S_OUT;
            S_OUT:    if (!out_ok || y_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Window RAM: synchronous read issued in READ, data consumed in UPDATE.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= x_q;
        end
        ram_dout <= ram[ram_addr];
    end

    // Per-channel state, capture registers and clear servicing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
                ptr[c] <= '0;
            end
            full        <= '0;
            pending_clr <= '0;
            rr_ptr      <= '0;
            ch_q        <= '0;
            x_q         <= '0;
            out_ok      <= 1'b0;
        end else begin
            // New pulses stay sticky even if the same channel is cleared now.
            pending_clr <= (pending_clr & ~clr_mask) | ch_clear;
            case (state)
                S_IDLE: begin
                    if (clr_any) begin
                        acc[clr_idx]  <= '0;
                        ptr[clr_idx]  <= '0;
                        full[clr_idx] <= 1'b0;
                    end else if (win_found) begin
                        ch_q   <= win_idx;
                        x_q    <= x_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        rr_ptr <= win_idx + CH_W'(1);
                    end
                end
                S_UPDATE: begin
                    acc[ch_q] <= acc[ch_q] + ACC_W'(x_q) - old_val;
                    ptr[ch_q] <= ptr[ch_q] + WIND_WIDTH'(1);
                    if (ptr[ch_q] == PTR_MAX) begin
                        full[ch_q] <= 1'b1;
                    end
                    out_ok <= full[ch_q] | (ptr[ch_q] == PTR_MAX);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mavg_channel_scheduler.md
Name: mavg_channel_scheduler

Overview:
- Time-multiplexes one moving-average datapath (shared window RAM plus accumulator update) across NUM_CH independent sample streams.
- A round-robin arbiter grants one pending channel at a time. A 4-state FSM sequences RAM read, accumulate and write, then presents the averaged result tagged with its channel number.
- Sits between the per-channel sample sources and the downstream filter consumers.
- Window size is a power of two; the average is the window sum shifted right by WIND_WIDTH.

Parameters:
- NUM_CH, 4: number of channels, ≥2, power of two.
- WIND_WIDTH, 4: log2 of the window depth; WIND_DEPTH = 2**WIND_WIDTH.
- DATA_WIDTH, 16: unsigned sample width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- x_data  in  NUM_CH*DATA_WIDTH  per-channel samples; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- x_valid  in  NUM_CH  per-channel sample valid.
- x_ready  out  NUM_CH  one-hot grant; a sample transfers when x_valid[c] && x_ready[c].
- ch_clear  in  NUM_CH  per-channel clear pulse.
- y_data  out  DATA_WIDTH  averaged output.
- y_ch  out  $clog2(NUM_CH)  channel tag of y_data.
- y_valid  out  1  output valid.
- y_ready  in  1  output accept.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM goes to IDLE.
  - All of the following are 0: x_ready, y_valid, y_data, y_ch, busy, every channel's accumulator, write pointer, fill flag and pending-clear bit.
  - The round-robin pointer is set so channel 0 has highest priority.
  - A reset asserted mid-operation abandons the in-flight sample. No output is produced for it.
- Storage:
  - Shared RAM of NUM_CH*WIND_DEPTH words, addressed {channel, ptr[channel]}.
  - Synchronous read, 1-cycle latency. Write port in the same block.
  - Contents are undefined after reset and never read unmasked.
- Per channel:
  - acc, DATA_WIDTH+WIND_WIDTH bits, unsigned.
  - ptr, WIND_WIDTH bits.
  - full flag.
  - pending_clr bit, set by a ch_clear pulse (sticky).
- IDLE:
  - If any pending_clr bit is set, the lowest-index such channel is cleared this cycle: acc=0, ptr=0, full=0, pending_clr=0. Clears take priority over samples. No output is produced.
  - Otherwise, the round-robin winner among x_valid is chosen, starting from the channel after the last grant. x_ready[winner] is driven high combinationally for this cycle only, and x_data is captured. Next state is READ and the round-robin pointer advances.
  - With no request, the FSM stays in IDLE.
- READ: RAM read at {ch, ptr[ch]}.
- UPDATE:
  - old = full[ch] ? ram_dout : 0.
  - acc[ch] <= acc[ch] + x - old. No overflow is possible by construction.
  - RAM write of x at {ch, ptr[ch]}.
  - ptr[ch] increments, wrapping WIND_DEPTH-1 to 0.
  - full[ch] is set when ptr[ch] was WIND_DEPTH-1.
  - out_ok is set to full[ch] | (ptr[ch]==WIND_DEPTH-1).
- OUT:
  - If out_ok: y_valid=1, y_data = acc[ch][MSBs above WIND_WIDTH] (truncating divide), y_ch = ch. These hold stable until y_ready. The transfer returns the FSM to IDLE.
  - If not out_ok: y_valid stays 0 and the FSM returns to IDLE next cycle.
- Throughput: minimum 4 cycles per sample. Grant-to-y_valid latency is 3 cycles.
- ch_clear timing:
  - ch_clear arriving in any state is latched and serviced at the next IDLE.
  - ch_clear for the channel currently in flight does not affect that sample's output.
  - Simultaneous clears are serviced one per IDLE cycle, lowest index first.
- No x_ready is asserted outside IDLE. x_valid may drop without penalty while its channel is not granted.

Test Plan (NUM_CH=4, WIND_WIDTH=2, DATA_WIDTH=16):
- Window fill: ch0 sends 4, 8, 12, 16, then 20.
  - No y_valid for the first 3 samples.
  - Then y_data=10, y_ch=0; then y_data=14.
  - Each y_valid occurs exactly 3 cycles after its grant.
- Fairness: x_valid=4'b1111 held from reset.
  - Grants go 0,1,2,3,0,1 in order.
  - Each x_ready pulses one cycle, with 4 cycles between grants.
- Backpressure: y_ready low for 5 cycles during OUT.
  - y_data, y_ch and y_valid stay stable.
  - No x_ready is issued.
  - Transfer occurs on the first cycle y_ready is high.
- Clear:
  - Ch1 is filled with 8,8,8,8; then ch_clear[1] is pulsed.
  - Ch1 then sends 4,4,4,4.
  - The first 3 of these produce no output; the 4th gives y_data=4.
  - Ch2 state is untouched throughout.
- Arithmetic:
  - 1,1,1,2 gives y_data=1 (truncation).
  - 0xFFFF×4 gives 0xFFFF.
  - Then 0: (3×0xFFFF)>>2 = 0xBFFF.
- Async reset: reset_n is dropped mid-UPDATE.
  - Outputs go to 0 without waiting for a clock edge.
  - After release, ch0 needs 4 fresh samples before y_valid.
